// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared constants for the memory arbiter: store-width codes carried on
//   d_we/m_we, the arbiter FSM state encoding, and a helper that turns a
//   requested d_we into the code actually issued to memory.
package mem_arbiter_pkg;

   // Width codes on d_we / m_we (one-hot for stores, all-zero for a read).
   localparam logic [2:0] WE_READ = 3'b000;
   localparam logic [2:0] WE_BYTE = 3'b100;
   localparam logic [2:0] WE_HALF = 3'b010;
   localparam logic [2:0] WE_WORD = 3'b001;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   // Any code that is not a legal store width is issued as a plain read.
   function automatic logic [2:0] we_sanitize(input logic [2:0] we);
      case (we)
         WE_BYTE, WE_HALF, WE_WORD: return we;
         default:                   return WE_READ;
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester arbiter (instruction fetch I, data D) in front of a single
//   memory port with a fixed read latency. One transaction in flight at a
//   time: IDLE (accept) -> ISSUE (m_en for one cycle) -> WAIT (LATENCY
//   cycles) -> IDLE, with the response pulsed on the granted port as the
//   FSM re-enters IDLE. Conflicts are resolved round-robin.
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   i_valid/i_addr/i_ready      instruction fetch request (read-only)
//   i_rdata/i_rvalid            instruction fetch response
//   d_valid/d_addr/d_wdata/d_we/d_ready   data request (d_we = width code)
//   d_rdata/d_rvalid            data response (read data or store ack)
//   m_en/m_addr/m_wdata/m_we/m_rdata      shared memory port
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ready,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_rvalid,
   input  logic              d_valid,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [2:0]        d_we,
   output logic              d_ready,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_rvalid,
   output logic              m_en,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic [2:0]        m_we,
   input  logic [DATA_W-1:0] m_rdata
);

   // WAIT lasts LATENCY cycles: counter loads LATENCY-1 and exits at zero.
   localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

   state_t     state;
   logic [1:0] cnt;
   // Port granted most recently; also identifies the transaction in flight.
   logic       last_d;
   logic       idle;
   logic       d_pick;

   // D wins when alone, or on conflict when I had the last grant.
   assign idle    = (state == ST_IDLE) && !rst;
   assign d_pick  = d_valid && (!i_valid || !last_d);
   assign d_ready = idle && d_pick;
   assign i_ready = idle && !d_pick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         last_d   <= 1'b0;
         m_en     <= 1'b0;
         m_we     <= WE_READ;
         m_addr   <= '0;
         m_wdata  <= '0;
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         i_rdata  <= '0;
         d_rdata  <= '0;
      end else begin
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (d_valid && d_ready) begin
                  state   <= ST_ISSUE;
                  last_d  <= 1'b1;
                  m_en    <= 1'b1;
                  m_addr  <= d_addr;
                  m_wdata <= d_wdata;
                  m_we    <= we_sanitize(d_we);
               end else if (i_valid && i_ready) begin
                  state   <= ST_ISSUE;
                  last_d  <= 1'b0;
                  m_en    <= 1'b1;
                  m_addr  <= i_addr;
                  m_we    <= WE_READ;
               end
            end
            ST_ISSUE: begin
               state <= ST_WAIT;
               m_en  <= 1'b0;
               m_we  <= WE_READ;
               cnt   <= CNT_INIT;
            end
            ST_WAIT: begin
               if (cnt == 2'd0) begin
                  // Capture and respond; the FSM is IDLE in the rvalid cycle.
                  state <= ST_IDLE;
                  if (last_d) begin
                     d_rvalid <= 1'b1;
                     d_rdata  <= m_rdata;
                  end else begin
                     i_rvalid <= 1'b1;
                     i_rdata  <= m_rdata;
                  end
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed stimulus with a scoreboard: every accepted request pushes its
//   expected issue and response into queues, and a negedge monitor pops and
//   compares them against the DUT. A second instance built with LATENCY=4
//   is exercised with a short directed sequence.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   // LATENCY=1 instance
   logic        i_valid, i_ready, i_rvalid, d_valid, d_ready, d_rvalid, m_en;
   logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
   logic [2:0]  d_we, m_we;

   // LATENCY=4 instance
   logic        i_valid4, i_ready4, i_rvalid4, d_valid4, d_ready4, d_rvalid4, m_en4;
   logic [31:0] i_addr4, i_rdata4, d_addr4, d_wdata4, d_rdata4, m_addr4, m_wdata4, m_rdata4;
   logic [2:0]  d_we4, m_we4;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_dut (
      .clk(clk), .rst(rst),
      .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready),
      .i_rdata(i_rdata), .i_rvalid(i_rvalid),
      .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
      .d_ready(d_ready), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
      .m_en(m_en), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
      .m_rdata(m_rdata));

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .i_valid(i_valid4), .i_addr(i_addr4), .i_ready(i_ready4),
      .i_rdata(i_rdata4), .i_rvalid(i_rvalid4),
      .d_valid(d_valid4), .d_addr(d_addr4), .d_wdata(d_wdata4), .d_we(d_we4),
      .d_ready(d_ready4), .d_rdata(d_rdata4), .d_rvalid(d_rvalid4),
      .m_en(m_en4), .m_addr(m_addr4), .m_wdata(m_wdata4), .m_we(m_we4),
      .m_rdata(m_rdata4));

   int ntot = 0;
   int npass = 0;
   int cyc = 0;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEAD_BEEF : ((a ^ 32'h5A5A_0000) + 32'h1111);
   endfunction

   function automatic logic [2:0] exp_we(input logic [2:0] w);
      case (w)
         3'b000, 3'b001, 3'b010, 3'b100: return w;
         default:                        return 3'b000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
   endtask

   // Memory models: read data is valid only in the cycle LATENCY after m_en,
   // garbage otherwise, so a wrong capture cycle shows up as wrong data.
   int          rdy = -1, rdy4 = -1;
   logic [31:0] mdat, mdat4;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (m_en)  begin rdy  <= cyc + 1; mdat  <= mem_f(m_addr);  end
      if (m_en4) begin rdy4 <= cyc + 4; mdat4 <= mem_f(m_addr4); end
   end
   assign m_rdata  = (cyc == rdy)  ? mdat  : (32'hBAD0_0000 ^ 32'(cyc));
   assign m_rdata4 = (cyc == rdy4) ? mdat4 : (32'hBAD4_0000 ^ 32'(cyc));

   typedef struct {
      bit          port;   // 1 = D
      logic [31:0] addr, wdata, data;
      logic [2:0]  we;
      int          iss, rsp;
   } txn_t;
   typedef struct { bit port; int cyc; } gnt_t;

   txn_t        iss_q[$], rsp_q[$];
   gnt_t        gq[$];
   logic [31:0] exp_ir = '0, exp_dr = '0;

   always @(negedge clk) begin : mon
      txn_t t;
      if (rst) begin
         chk("rst_ready",  {i_ready, d_ready}, 0);
         chk("rst_men",    m_en, 0);
         chk("rst_mwe",    m_we, 0);
         chk("rst_maddr",  m_addr, 0);
         chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
         chk("rst_rdata",  {i_rdata, d_rdata}, 0);
         iss_q.delete(); rsp_q.delete();
         exp_ir = '0; exp_dr = '0;
      end else begin
         chk("one_ready", i_ready & d_ready, 0);
         if ((i_valid && i_ready) || (d_valid && d_ready)) begin
            t.port  = d_valid && d_ready;
            t.addr  = t.port ? d_addr : i_addr;
            t.wdata = d_wdata;
            t.we    = t.port ? exp_we(d_we) : 3'b000;
            t.data  = mem_f(t.addr);
            t.iss   = cyc + 1;
            t.rsp   = cyc + 3;
            iss_q.push_back(t);
            rsp_q.push_back(t);
            gq.push_back('{t.port, cyc});
         end
         if (iss_q.size() > 0 && iss_q[0].iss == cyc) begin
            t = iss_q.pop_front();
            chk("issue_men",   m_en, 1);
            chk("issue_maddr", m_addr, t.addr);
            chk("issue_mwe",   m_we, t.we);
            if (t.port) chk("issue_mwdata", m_wdata, t.wdata);
         end else begin
            chk("idle_men", m_en, 0);
            chk("idle_mwe", m_we, 0);
         end
         if (rsp_q.size() > 0 && rsp_q[0].rsp == cyc) begin
            t = rsp_q.pop_front();
            chk("rsp_i_rvalid", i_rvalid, !t.port);
            chk("rsp_d_rvalid", d_rvalid, t.port);
            if (t.port) exp_dr = t.data; else exp_ir = t.data;
         end else begin
            chk("no_rvalid", {i_rvalid, d_rvalid}, 0);
         end
         chk("i_rdata", i_rdata, exp_ir);
         chk("d_rdata", d_rdata, exp_dr);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_req(input bit port, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] we);
      int n = 0;
      if (port) begin d_valid = 1; d_addr = a; d_wdata = wd; d_we = we; end
      else      begin i_valid = 1; i_addr = a; end
      do begin @(negedge clk); n++; end while (!(port ? d_ready : i_ready) && n < 20);
      chk("accept_timeout", n < 20, 1);
      @(posedge clk); #1;
      if (port) d_valid = 0; else i_valid = 0;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int n, t4;
      rst = 1;
      i_valid = 0; i_addr = '0; d_valid = 0; d_addr = '0; d_wdata = '0; d_we = '0;
      i_valid4 = 0; i_addr4 = '0; d_valid4 = 0; d_addr4 = '0; d_wdata4 = '0; d_we4 = '0;
      idle(3);
      rst = 0;

      // Instruction read of 0x10 -> DEADBEEF three cycles after accept
      do_req(0, 32'h10, 32'h0, 3'b000);        idle(4);
      // Stores of each width, then illegal codes that must issue as reads
      do_req(1, 32'h20, 32'hAB, 3'b100);        idle(4);
      do_req(1, 32'h24, 32'h1234, 3'b010);      idle(4);
      do_req(1, 32'h28, 32'hCAFE_F00D, 3'b001); idle(4);
      do_req(1, 32'h2C, 32'h55, 3'b011);        idle(4);
      do_req(1, 32'h30, 32'h66, 3'b111);        idle(4);
      do_req(1, 32'h34, 32'h0, 3'b000);         idle(4);
      do_req(0, 32'h38, 32'h0, 3'b000);         idle(4);

      // Both requesters valid from reset: D, I, D, I every 3 cycles
      rst = 1;
      i_valid = 1; i_addr = 32'h100;
      d_valid = 1; d_addr = 32'h200; d_wdata = 32'h0; d_we = 3'b000;
      gq.delete();
      idle(1);
      rst = 0;
      idle(11);
      i_valid = 0; d_valid = 0;
      idle(6);
      chk("alt_count", gq.size(), 4);
      for (int k = 0; k < gq.size() && k < 4; k++) begin
         chk("alt_port", gq[k].port, (k % 2) == 0);
         if (k > 0) chk("alt_gap", gq[k].cyc - gq[k-1].cyc, 3);
      end

      // Reset in WAIT: outputs clear at once, no response, then recover
      do_req(0, 32'h44, 32'h0, 3'b000);
      idle(1);
      rst = 1;
      #1;
      chk("async_maddr",  m_addr, 0);
      chk("async_ready",  i_ready, 0);
      chk("async_rvalid", {i_rvalid, d_rvalid}, 0);
      idle(1);
      rst = 0;
      idle(3);
      do_req(1, 32'h48, 32'h0, 3'b000);  idle(4);
      do_req(0, 32'h4C, 32'h0, 3'b000);  idle(4);

      // LATENCY=4 instance: m_en at T+1, capture in T+5, rvalid at T+6
      i_valid4 = 1; i_addr4 = 32'h40;
      n = 0;
      do begin @(negedge clk); n++; end while (!i_ready4 && n < 20);
      chk("l4_accept", n < 20, 1);
      t4 = cyc;
      @(posedge clk); #1;
      i_valid4 = 0;
      repeat (8) begin
         @(negedge clk);
         chk("l4_men",     m_en4, cyc == t4 + 1);
         chk("l4_rvalid",  i_rvalid4, cyc == t4 + 6);
         chk("l4_drvalid", {d_rvalid4, d_ready4}, 0);
         chk("l4_mwe",     m_we4, 0);
         if (cyc == t4 + 1) chk("l4_maddr", m_addr4, 32'h40);
         if (cyc == t4 + 6) chk("l4_rdata", i_rdata4, mem_f(32'h40));
      end
      chk("l4_d_rdata", d_rdata4, 0);

      chk("q_empty", iss_q.size() + rsp_q.size(), 0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 32, data width of all ports.
REQ-003 SHALL have parameter LATENCY, default 1, backing-memory read latency in cycles, legal range 1..4.
REQ-004 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports i_valid in 1, i_addr in ADDR_W, i_ready out 1: instruction-fetch request; read-only.
REQ-007 SHALL have ports i_rdata out DATA_W, i_rvalid out 1: instruction-fetch response.
REQ-008 SHALL have ports d_valid in 1, d_addr in ADDR_W, d_wdata in DATA_W, d_we in 3, d_ready out 1: data request. d_we is 000 read, 100 byte, 010 half, 001 word store.
REQ-009 SHALL have ports d_rdata out DATA_W, d_rvalid out 1: data response (read data or store ack).
REQ-010 SHALL have ports m_en out 1, m_addr out ADDR_W, m_wdata out DATA_W, m_we out 3, m_rdata in DATA_W: single shared memory port.

Function
REQ-011 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE, with one transaction outstanding at most.
REQ-012 SHALL assert i_ready/d_ready only in IDLE, combinationally, to at most one requester; a request is accepted in cycle T when valid&ready.
REQ-013 SHALL arbitrate round-robin: sole requester wins; on conflict the port not granted last wins; after reset "last granted" = I, so D wins the first conflict.
REQ-014 SHALL register the accepted addr/wdata/we at end of T and drive m_en=1 with them for exactly cycle T+1 (ISSUE); m_en=0 and m_we=000 in all other cycles.
REQ-015 SHALL drive m_we=000 for I grants; any d_we value other than 000/001/010/100 SHALL issue as a read (m_we=000).
REQ-016 SHALL stay in WAIT for LATENCY cycles using a down-counter and capture m_rdata at the end of cycle T+1+LATENCY.
REQ-017 SHALL pulse the granted port's rvalid for exactly one cycle, T+2+LATENCY, with the captured data on its rdata; the other rvalid stays 0.
REQ-018 SHALL pulse d_rvalid for stores too; d_rdata then carries whatever m_rdata showed at capture and has no defined meaning.
REQ-019 SHALL hold i_rdata/d_rdata stable between responses; only its own response updates each.
REQ-020 SHALL re-enter IDLE in the rvalid cycle, so the next accept is no earlier than T+2+LATENCY: one transaction per LATENCY+2 cycles.
REQ-021 SHALL require requesters to hold valid and payload until ready; a valid dropped before accept has no effect.
REQ-022 SHALL pass addresses unmodified; no alignment checking.

Reset
REQ-023 On rst assertion, at any state, the block SHALL asynchronously force IDLE, m_en=0, m_we=000, i_rvalid=d_rvalid=0, m_addr/m_wdata/rdata=0, counter=0, last-granted=I.
REQ-024 A transaction in flight at reset SHALL be discarded with no rvalid; ready SHALL be 0 while rst is high.

Structure
REQ-025 The d_we/m_we width codes and FSM state encodings SHALL live in the shared constants header beside the word-size macros.
REQ-026 SHALL be one flat module (FSM, latency counter, grant register); no sub-module.

Verification
REQ-027 With LATENCY=1, I-only read of 0x10 accepted at T and m_rdata=0xDEADBEEF in T+2 -> m_en high at T+1 only, i_rvalid at T+3 with i_rdata=0xDEADBEEF.
REQ-028 Both valid from reset, continuously -> grants alternate D,I,D,I; each accept is 3 cycles after the previous (LATENCY=1).
REQ-029 D store d_we=100, addr 0x20, wdata 0xAB -> one ISSUE cycle with m_we=100, m_addr=0x20, m_wdata=0xAB; d_rvalid one pulse; i_rvalid stays 0.
REQ-030 D request with d_we=011 -> m_we=000 and d_rvalid is still returned.
REQ-031 rst asserted during WAIT -> outputs cleared immediately; no rvalid; a fresh request afterwards completes normally.
REQ-032 LATENCY=4 build -> m_rdata is sampled in cycle T+5 and rvalid is at T+6.
